// File: rtl/sd_sec_arbiter.sv
// Two-port arbiter for the shared SD sector controller: grant, start pulse, data routing, timeout, guard gap.
// Latency: req in IDLE -> gnt next cycle -> rd/wr start pulse the cycle after gnt.
// Backpressure: req is held until gnt; further grants wait for op end plus GAP_CYCLES idle cycles.
module sd_sec_arbiter #(
    parameter int ROUND_ROBIN  = 1,
    parameter int GAP_CYCLES   = 255,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_init_done,
    input  logic [1:0]  req,
    input  logic [1:0]  req_wr,
    input  logic [63:0] req_sec_addr,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [1:0]  rd_val_en_o,
    output logic [15:0] rd_val_data_o,
    output logic [1:0]  wr_req_o,
    input  logic [31:0] wr_data_i,
    output logic        rd_start_en,
    output logic [31:0] rd_sec_addr,
    input  logic        rd_busy,
    input  logic        rd_val_en,
    input  logic [15:0] rd_val_data,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic [15:0] wr_data
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_BUSY, S_XFER, S_GAP} state_t;

    localparam logic [15:0] TO_LAST  = 16'(BUSY_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state, state_nxt;
    logic        owner, last_owner, dir, pick;
    logic [31:0] lat_addr;
    logic [15:0] timer;
    logic        sel_busy, grant_ok, active;
    logic [1:0]  gnt_nxt, done_nxt, err_nxt;
    logic        rd_start_nxt, wr_start_nxt;

    assign sel_busy      = dir ? wr_busy : rd_busy;
    assign grant_ok      = sd_init_done && (|req);
    assign active        = (state == S_WAIT_BUSY) || (state == S_XFER);
    assign rd_val_data_o = rd_val_data;

    // Contention: round robin favours the port that did not own the last op.
    always_comb begin
        if (req == 2'b11)
            pick = (ROUND_ROBIN != 0) ? ~last_owner : 1'b0;
        else
            pick = req[1];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (grant_ok) state_nxt = S_START;
            S_START:     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (sel_busy)
                    state_nxt = S_XFER;
                else if (timer == TO_LAST)
                    state_nxt = S_GAP;
            end
            S_XFER:      if (!sel_busy) state_nxt = S_GAP;
            S_GAP:       if (timer == GAP_LAST) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt      = 2'b00;
        done_nxt     = 2'b00;
        err_nxt      = 2'b00;
        rd_start_nxt = 1'b0;
        wr_start_nxt = 1'b0;
        rd_val_en_o  = 2'b00;
        wr_req_o     = 2'b00;
        wr_data      = 16'h0000;
        if (state == S_IDLE && grant_ok)
            gnt_nxt = pick ? 2'b10 : 2'b01;
        if (state == S_START) begin
            rd_start_nxt = !dir;
            wr_start_nxt = dir;
        end
        if (state == S_WAIT_BUSY && !sel_busy && timer == TO_LAST)
            err_nxt = owner ? 2'b10 : 2'b01;
        if (state == S_XFER && !sel_busy)
            done_nxt = owner ? 2'b10 : 2'b01;
        if (active) begin
            if (!dir) begin
                rd_val_en_o[owner] = rd_val_en;
            end else begin
                wr_req_o[owner] = wr_req;
                wr_data         = owner ? wr_data_i[31:16] : wr_data_i[15:0];
            end
        end
    end

    // Timer restarts on every state change, serving as busy timeout and gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt         <= 2'b00;
            done        <= 2'b00;
            err         <= 2'b00;
            rd_start_en <= 1'b0;
            wr_start_en <= 1'b0;
            rd_sec_addr <= 32'h0;
            wr_sec_addr <= 32'h0;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            dir         <= 1'b0;
            lat_addr    <= 32'h0;
            timer       <= 16'h0;
        end else begin
            gnt         <= gnt_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
            rd_start_en <= rd_start_nxt;
            wr_start_en <= wr_start_nxt;
            if (state == S_IDLE && grant_ok) begin
                owner    <= pick;
                dir      <= req_wr[pick];
                lat_addr <= pick ? req_sec_addr[63:32] : req_sec_addr[31:0];
            end
            if (state == S_START) begin
                if (dir)
                    wr_sec_addr <= lat_addr;
                else
                    rd_sec_addr <= lat_addr;
            end
            if (state != S_GAP && state_nxt == S_GAP)
                last_owner <= owner;
            if (state_nxt != state)
                timer <= 16'h0;
            else if (timer != 16'hFFFF)
                timer <= timer + 16'h1;
        end
    end

endmodule

// File: tb/tb_sd_sec_arbiter.sv
// Directed bench for sd_sec_arbiter: a round-robin and a fixed-priority instance run in lockstep.
module tb_sd_sec_arbiter;

    localparam int GAP = 6;
    localparam int TO  = 64;

    logic        clk, rst, sd_init_done;
    logic [1:0]  req, req_wr;
    logic [63:0] req_sec_addr;
    logic [31:0] wr_data_i;
    logic        rd_busy, rd_val_en, wr_busy, wr_req;
    logic [15:0] rd_val_data;

    logic [1:0]  gnt_r, done_r, err_r, rd_val_en_o_r, wr_req_o_r;
    logic [15:0] rd_val_data_o_r, wr_data_r;
    logic        rd_start_en_r, wr_start_en_r;
    logic [31:0] rd_sec_addr_r, wr_sec_addr_r;

    logic [1:0]  gnt_f, done_f, err_f, rd_val_en_o_f, wr_req_o_f;
    logic [15:0] rd_val_data_o_f, wr_data_f;
    logic        rd_start_en_f, wr_start_en_f;
    logic [31:0] rd_sec_addr_f, wr_sec_addr_f;

    int n_cmp = 0;
    int n_bad = 0;

    sd_sec_arbiter #(.ROUND_ROBIN(1), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TO)) u_rr (
        .clk(clk), .rst(rst), .sd_init_done(sd_init_done), .req(req), .req_wr(req_wr),
        .req_sec_addr(req_sec_addr), .gnt(gnt_r), .done(done_r), .err(err_r),
        .rd_val_en_o(rd_val_en_o_r), .rd_val_data_o(rd_val_data_o_r), .wr_req_o(wr_req_o_r),
        .wr_data_i(wr_data_i), .rd_start_en(rd_start_en_r), .rd_sec_addr(rd_sec_addr_r),
        .rd_busy(rd_busy), .rd_val_en(rd_val_en), .rd_val_data(rd_val_data),
        .wr_start_en(wr_start_en_r), .wr_sec_addr(wr_sec_addr_r), .wr_busy(wr_busy),
        .wr_req(wr_req), .wr_data(wr_data_r)
    );

    sd_sec_arbiter #(.ROUND_ROBIN(0), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TO)) u_fp (
        .clk(clk), .rst(rst), .sd_init_done(sd_init_done), .req(req), .req_wr(req_wr),
        .req_sec_addr(req_sec_addr), .gnt(gnt_f), .done(done_f), .err(err_f),
        .rd_val_en_o(rd_val_en_o_f), .rd_val_data_o(rd_val_data_o_f), .wr_req_o(wr_req_o_f),
        .wr_data_i(wr_data_i), .rd_start_en(rd_start_en_f), .rd_sec_addr(rd_sec_addr_f),
        .rd_busy(rd_busy), .rd_val_en(rd_val_en), .rd_val_data(rd_val_data),
        .wr_start_en(wr_start_en_f), .wr_sec_addr(wr_sec_addr_f), .wr_busy(wr_busy),
        .wr_req(wr_req), .wr_data(wr_data_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        init;
        logic [1:0]  req;
        logic [1:0]  req_wr;
        logic [63:0] addr;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_gnt_fp;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vt[5];

    initial begin
        int cnt, p0_cnt, p1_cnt, dat_bad;

        vt[0] = '{1'b1, 2'b01, 2'b00, {32'h77, 32'd16640},      2'b01, 2'b01, 1'b1, 1'b0, 32'd16640};
        vt[1] = '{1'b1, 2'b10, 2'b10, {32'h1234, 32'h99},       2'b10, 2'b10, 1'b0, 1'b1, 32'h1234};
        vt[2] = '{1'b1, 2'b11, 2'b00, {32'hB, 32'hA},           2'b01, 2'b01, 1'b1, 1'b0, 32'hA};
        vt[3] = '{1'b1, 2'b11, 2'b01, {32'hD, 32'hC},           2'b10, 2'b01, 1'b1, 1'b0, 32'hD};
        vt[4] = '{1'b0, 2'b01, 2'b00, {32'h0, 32'h55},          2'b00, 2'b00, 1'b0, 1'b0, 32'h0};

        rst = 1'b1; sd_init_done = 1'b0; req = 2'b00; req_wr = 2'b00; req_sec_addr = 64'h0;
        wr_data_i = 32'h0; rd_busy = 1'b0; wr_busy = 1'b0; rd_val_en = 1'b0; wr_req = 1'b0;
        rd_val_data = 16'h0;
        repeat (3) tick();
        chk("reset_gnt", {62'h0, gnt_r}, 64'h0);
        chk("reset_pulses", {58'h0, done_r, err_r, rd_start_en_r, wr_start_en_r}, 64'h0);
        chk("reset_addrs", {rd_sec_addr_r, wr_sec_addr_r}, 64'h0);
        rst = 1'b0;

        // Table: one full op per row, or a refused grant.
        for (int i = 0; i < 5; i++) begin
            sd_init_done = vt[i].init; req = vt[i].req; req_wr = vt[i].req_wr;
            req_sec_addr = vt[i].addr;
            tick();
            chk($sformatf("v%0d_gnt", i), {62'h0, gnt_r}, {62'h0, vt[i].exp_gnt});
            chk($sformatf("v%0d_gnt_fp", i), {62'h0, gnt_f}, {62'h0, vt[i].exp_gnt_fp});
            req = 2'b00;
            tick();
            chk($sformatf("v%0d_starts", i), {62'h0, rd_start_en_r, wr_start_en_r},
                {62'h0, vt[i].exp_rd, vt[i].exp_wr});
            if (vt[i].exp_rd) chk($sformatf("v%0d_rd_addr", i), {32'h0, rd_sec_addr_r}, {32'h0, vt[i].exp_addr});
            if (vt[i].exp_wr) chk($sformatf("v%0d_wr_addr", i), {32'h0, wr_sec_addr_r}, {32'h0, vt[i].exp_addr});
            if (vt[i].exp_gnt != 2'b00) begin
                rd_busy = 1'b1; wr_busy = 1'b1; rd_val_en = 1'b1; wr_req = 1'b1;
                wr_data_i = 32'hBEEF_1111;
                tick();
                chk($sformatf("v%0d_rd_route", i), {62'h0, rd_val_en_o_r},
                    {62'h0, vt[i].exp_rd ? vt[i].exp_gnt : 2'b00});
                chk($sformatf("v%0d_wr_route", i), {62'h0, wr_req_o_r},
                    {62'h0, vt[i].exp_wr ? vt[i].exp_gnt : 2'b00});
                chk($sformatf("v%0d_wr_data", i), {48'h0, wr_data_r},
                    {48'h0, vt[i].exp_wr ? (vt[i].exp_gnt[1] ? 16'hBEEF : 16'h1111) : 16'h0});
                rd_busy = 1'b0; wr_busy = 1'b0; rd_val_en = 1'b0; wr_req = 1'b0;
                tick();
                chk($sformatf("v%0d_done", i), {62'h0, done_r}, {62'h0, vt[i].exp_gnt});
                repeat (GAP) tick();
            end
        end

        // Init gating, then a long read with 256 data beats.
        sd_init_done = 1'b0; req = 2'b01; req_wr = 2'b00; req_sec_addr = {32'h0, 32'd16640};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("noinit_gnt", {62'h0, gnt_r}, 64'h0);
        end
        sd_init_done = 1'b1;
        tick();
        chk("init_gnt", {62'h0, gnt_r}, 64'h1);
        req = 2'b00;
        tick();
        chk("long_start", {31'h0, rd_start_en_r, rd_sec_addr_r}, {31'h0, 1'b1, 32'd16640});
        repeat (8) tick();
        rd_busy = 1'b1;
        p0_cnt = 0; p1_cnt = 0; dat_bad = 0;
        for (int i = 0; i < 512; i++) begin
            rd_val_en = i[0];
            rd_val_data = 16'(i * 3);
            #1;
            if (rd_val_en_o_r[0]) p0_cnt++;
            if (rd_val_en_o_r[1]) p1_cnt++;
            if (rd_val_data_o_r !== 16'(i * 3)) dat_bad++;
            tick();
        end
        rd_busy = 1'b0; rd_val_en = 1'b0;
        chk("long_no_early_done", {62'h0, done_r}, 64'h0);
        tick();
        chk("long_done", {62'h0, done_r}, 64'h1);
        chk("long_p0_beats", 64'(p0_cnt), 64'd256);
        chk("long_p1_beats", 64'(p1_cnt), 64'd0);
        chk("long_data", 64'(dat_bad), 64'd0);

        // Port 1 write whose busy never rises.
        req = 2'b10; req_wr = 2'b10; req_sec_addr = {32'h5555, 32'h0};
        cnt = 0;
        while (gnt_r == 2'b00 && cnt < 50) begin tick(); cnt++; end
        chk("to_gap_len", 64'(cnt), 64'(GAP + 1));
        chk("to_gnt", {62'h0, gnt_r}, 64'h2);
        req = 2'b00;
        tick();
        chk("to_start", {31'h0, wr_start_en_r, wr_sec_addr_r}, {31'h0, 1'b1, 32'h5555});
        cnt = 0;
        while (err_r == 2'b00 && cnt < 200) begin tick(); cnt++; end
        chk("to_latency", 64'(cnt), 64'(TO));
        chk("to_err", {60'h0, err_r, done_r}, {60'h0, 2'b10, 2'b00});
        req = 2'b01; req_wr = 2'b00;
        cnt = 0;
        while (gnt_r == 2'b00 && cnt < 50) begin tick(); cnt++; end
        chk("after_to_gnt", {62'h0, gnt_r}, 64'h1);
        chk("after_to_gap", 64'(cnt), 64'(GAP + 1));
        req = 2'b00;
        tick();
        rd_busy = 1'b1; rd_val_en = 1'b1;
        tick();
        tick();
        chk("xfer_route", {62'h0, rd_val_en_o_r}, 64'h1);
        rst = 1'b1;
        tick();
        chk("rst_mid_pulses", {58'h0, gnt_r, done_r, err_r}, 64'h0);
        chk("rst_mid_route", {44'h0, rd_val_en_o_r, wr_req_o_r, wr_data_r}, 64'h0);
        chk("rst_mid_start", {62'h0, rd_start_en_r, wr_start_en_r}, 64'h0);
        rd_busy = 1'b0; rd_val_en = 1'b0;

        // Continuous contention: round robin alternates, fixed priority never yields.
        rst = 1'b0; req = 2'b11; req_wr = 2'b00;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            while (gnt_r == 2'b00 && cnt < 50) begin tick(); cnt++; end
            chk($sformatf("rr%0d_gnt", k), {62'h0, gnt_r}, {62'h0, k[0] ? 2'b10 : 2'b01});
            chk($sformatf("fp%0d_gnt", k), {62'h0, gnt_f}, 64'h1);
            if (k > 0) chk($sformatf("rr%0d_gap", k), 64'(cnt), 64'(GAP + 1));
            tick();
            rd_busy = 1'b1;
            tick();
            rd_busy = 1'b0;
            tick();
            chk($sformatf("rr%0d_done", k), {60'h0, done_r, done_f},
                {60'h0, k[0] ? 2'b10 : 2'b01, 2'b01});
        end
        req = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
